// File: rtl/clock_pkg.sv
// Shared types and constants for the clock controller.
// FSM state encoding, digit limits and hour wrap helper.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  localparam logic [4:0] HOUR_MAX     = 5'd23;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_ONES_MAX = 4'd9;

  // Out-of-range hours also wrap to 0.
  function automatic logic [4:0] hour_next(input logic [4:0] h);
    return (h >= HOUR_MAX) ? 5'd0 : h + 5'd1;
  endfunction

endpackage

// File: rtl/bcd60_counter.sv
// Two-digit BCD mod-60 counter with sync clear and carry-out.
// Ports: clk, rst_n, inc, clr -> tens, ones (registered), carry (comb).
module bcd60_counter
  import clock_pkg::*;
#(
  parameter logic [3:0] TENS_INIT = 4'd0,
  parameter logic [3:0] ONES_INIT = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    at_max = (tens_q >= BCD_TENS_MAX)
          && (ones_q >= BCD_ONES_MAX);
    carry  = inc && at_max && !clr;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc) begin
      if (ones_q >= BCD_ONES_MAX) begin
        ones_d = 4'd0;
        tens_d = (tens_q >= BCD_TENS_MAX)
               ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= TENS_INIT;
      ones_q <= ONES_INIT;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/clock_ctrl.sv
// Time-keeping, set-time FSM and display scan/mode control.
// In: clk, rst_n, ticks, buttons. Out: BCD sec/min, hour, control, flags, set_state.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter logic [4:0] HOUR_INIT = 5'd0,
  parameter logic [5:0] MIN_INIT  = 6'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_scan,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_mode,
  input  logic       btn_disp,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [4:0] hour,
  output logic [1:0] control,
  output logic       change_mode,
  output logic       to_sec,
  output logic [1:0] set_state
);

  localparam logic [3:0] MIN_TENS = 4'(MIN_INIT / 6'd10);
  localparam logic [3:0] MIN_ONES = 4'(MIN_INIT % 6'd10);

  state_t     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [1:0] control_q, control_d;
  logic       change_mode_q, change_mode_d;
  logic       to_sec_q, to_sec_d;

  logic is_run, is_set_hour, is_set_min;
  logic sec_inc, sec_clr, sec_carry;
  logic min_inc, min_carry;

  assign is_run      = (state_q == ST_RUN);
  assign is_set_hour = (state_q == ST_SET_HOUR);
  assign is_set_min  = (state_q == ST_SET_MIN);

  // A concurrent btn_set wins over btn_inc.
  assign sec_inc = is_run && tick_1hz;
  assign sec_clr = is_set_min && btn_set;
  assign min_inc = (is_run && sec_carry)
                || (is_set_min && btn_inc && !btn_set);

  bcd60_counter #(
    .TENS_INIT (4'd0),
    .ONES_INIT (4'd0)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .tens  (sec2),
    .ones  (sec1),
    .carry (sec_carry)
  );

  bcd60_counter #(
    .TENS_INIT (MIN_TENS),
    .ONES_INIT (MIN_ONES)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (min2),
    .ones  (min1),
    .carry (min_carry)
  );

  always_comb begin
    state_d       = state_q;
    hour_d        = hour_q;
    control_d     = control_q;
    change_mode_d = change_mode_q ^ btn_mode;
    to_sec_d      = to_sec_q ^ btn_disp;
    if (tick_scan) control_d = control_q + 2'd1;
    case (state_q)
      ST_RUN: begin
        // Minute wrap only reaches the hour while running.
        if (min_carry) hour_d = hour_next(hour_q);
        if (btn_set) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (btn_set) state_d = ST_SET_MIN;
        else if (btn_inc) hour_d = hour_next(hour_q);
      end
      ST_SET_MIN: begin
        if (btn_set) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (hour_d > HOUR_MAX) hour_d = 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      hour_q        <= HOUR_INIT;
      control_q     <= 2'd0;
      change_mode_q <= 1'b0;
      to_sec_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hour_q        <= hour_d;
      control_q     <= control_d;
      change_mode_q <= change_mode_d;
      to_sec_q      <= to_sec_d;
    end
  end

  assign hour        = hour_q;
  assign control     = control_q;
  assign change_mode = change_mode_q;
  assign to_sec      = to_sec_q;
  assign set_state   = state_q;

endmodule
